thunderbird: RTL and testbench
==============================

THUNDERBIRD -- requirements
Module: thunderbird

Interface
REQ-001 Parameter: STEP_CYCLES, default 1, number of Clk cycles each light state is held (legal range 1..65535).
REQ-002 Clk  input  1  system clock; all state changes on its rising edge; the block's only clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 left  input  1  left-turn request, level-sensitive, synchronous to Clk.
REQ-005 right  input  1  right-turn request, level-sensitive, synchronous to Clk.
REQ-006 L  output  3  left lamps {LA,LB,LC}, MSB = LA (innermost), 1 = lamp lit.
REQ-007 R  output  3  right lamps {RA,RB,RC}, MSB = RA (innermost), 1 = lamp lit.

Function
REQ-008 The block SHALL be a Moore FSM; L and R SHALL be decoded from the state register only, with no combinational path from left/right to the outputs.
REQ-009 States and outputs: IDLE L=000 R=000; L1 L=100 R=000; L2 L=110 R=000; L3 L=111 R=000; R1 L=000 R=100; R2 L=000 R=110; R3 L=000 R=111; HAZ L=111 R=111.
REQ-010 A step counter SHALL advance the FSM only when it reaches STEP_CYCLES-1, then clear; with STEP_CYCLES=1 the FSM advances every rising edge.
REQ-011 From IDLE on a step: left=1 and right=1 -> HAZ; left=1 only -> L1; right=1 only -> R1; neither -> IDLE.
REQ-012 Left sequence L1->L2->L3->IDLE SHALL advance unconditionally, with inputs ignored until IDLE is reached.
REQ-013 Right sequence R1->R2->R3->IDLE SHALL advance unconditionally, with inputs ignored until IDLE is reached.
REQ-014 HAZ SHALL always go to IDLE on the next step, so held left=right=1 flashes all six lamps on/off with period 2*STEP_CYCLES.
REQ-015 Held left=1 SHALL repeat 000,100,110,111 with period 4*STEP_CYCLES, and held right=1 SHALL do the same on R.
REQ-016 Inputs SHALL be sampled only at step edges in IDLE; a request shorter than one step that misses such an edge SHALL be ignored.
REQ-017 At most one side SHALL be lit unless in HAZ; L and R SHALL never both be nonzero outside HAZ.
REQ-018 Unused or illegal state encodings SHALL recover to IDLE on the next rising edge.

Reset
REQ-019 While reset=0, the state SHALL be IDLE and the step counter 0 immediately, independent of Clk, and L=000, R=000.
REQ-020 Reset asserted mid-sequence (any of L1..R3 or HAZ) SHALL abort it and clear all lamps without waiting for a clock edge.
REQ-021 On the first rising edge after reset returns to 1, the FSM SHALL evaluate left/right per REQ-011.

Verification
REQ-022 With STEP_CYCLES=1, release reset, then hold left=1, right=0 for 5 edges -> L sequence is 100,110,111,000,100 and R stays 000.
REQ-023 Hold right=1, left=0 -> R sequence is 100,110,111,000 repeating and L stays 000; dropping right at R1 still completes R2, R3, then IDLE.
REQ-024 Hold left=1, right=1 from IDLE -> L=R=111 and L=R=000 alternate every edge; asserting both during L2 gives L3, IDLE, then HAZ.
REQ-025 Assert reset=0 between clock edges during HAZ or L3 -> L=R=000 before the next edge; hold left=1 with reset=0 -> outputs stay 000.
REQ-026 With STEP_CYCLES=3, hold left=1 -> each of 100,110,111,000 lasts exactly 3 cycles.

Source files
------------

// File: rtl/thunderbird.sv
// -----------------------------------------------------------------------------
// thunderbird -- sequential turn-signal / hazard lamp controller
//
// Moore FSM that drives three left lamps and three right lamps in the
// classic "sweeping outward" pattern. A free-running step counter sets the
// pace: the FSM only moves on a step, and each lamp pattern is held for
// STEP_CYCLES clock cycles.
//
// Parameters
//   STEP_CYCLES : clock cycles per lamp pattern (1..65535)
//
// Ports
//   Clk    in   system clock, rising edge
//   reset  in   asynchronous reset, active low
//   left   in   left-turn request (level, sampled at steps in IDLE only)
//   right  in   right-turn request (level, sampled at steps in IDLE only)
//   L      out  left lamps  {LA,LB,LC}, LA innermost, 1 = lit
//   R      out  right lamps {RA,RB,RC}, RA innermost, 1 = lit
// -----------------------------------------------------------------------------
module thunderbird #(
   parameter int unsigned STEP_CYCLES = 1
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic       left,
   input  logic       right,
   output logic [2:0] L,
   output logic [2:0] R
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      L1   = 3'd1,
      L2   = 3'd2,
      L3   = 3'd3,
      R1   = 3'd4,
      R2   = 3'd5,
      R3   = 3'd6,
      HAZ  = 3'd7
   } state_t;

   // Terminal count of the step counter; 16 bits covers the full range.
   localparam logic [15:0] STEP_LAST = 16'(STEP_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;
   logic [15:0] cnt;
   logic        step;

   assign step = (cnt == STEP_LAST);

   // Free-running pacing counter; wraps exactly when a step fires.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (step) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state. Sequences run unconditionally once started; requests are
   // only looked at from IDLE. The default arm catches any corrupted
   // encoding and returns to IDLE without waiting for a step.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (step) begin
               if (left && right)  state_nxt = HAZ;
               else if (left)      state_nxt = L1;
               else if (right)     state_nxt = R1;
               else                state_nxt = IDLE;
            end
         end
         L1:  if (step) state_nxt = L2;
         L2:  if (step) state_nxt = L3;
         L3:  if (step) state_nxt = IDLE;
         R1:  if (step) state_nxt = R2;
         R2:  if (step) state_nxt = R3;
         R3:  if (step) state_nxt = IDLE;
         HAZ: if (step) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Lamp decode from the state register only: no input-to-output path,
   // and only HAZ lights both sides.
   always_comb begin
      L = 3'b000;
      R = 3'b000;
      case (state)
         L1:  L = 3'b100;
         L2:  L = 3'b110;
         L3:  L = 3'b111;
         R1:  R = 3'b100;
         R2:  R = 3'b110;
         R3:  R = 3'b111;
         HAZ: begin
            L = 3'b111;
            R = 3'b111;
         end
         default: begin
            L = 3'b000;
            R = 3'b000;
         end
      endcase
   end

endmodule

// File: tb/tb_thunderbird.sv
// -----------------------------------------------------------------------------
// tb_thunderbird -- directed self-checking bench for thunderbird.
// Two instances share one clock: dut (STEP_CYCLES=1) and dut3 (STEP_CYCLES=3).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_thunderbird;

   logic       Clk = 1'b0;
   logic       reset, left, right;
   logic [2:0] L, R;
   logic       reset3, left3, right3;
   logic [2:0] L3o, R3o;

   int passed = 0;
   int total  = 0;

   always #5 Clk = ~Clk;

   thunderbird #(.STEP_CYCLES(1)) dut (
      .Clk(Clk), .reset(reset), .left(left), .right(right), .L(L), .R(R)
   );

   thunderbird #(.STEP_CYCLES(3)) dut3 (
      .Clk(Clk), .reset(reset3), .left(left3), .right(right3), .L(L3o), .R(R3o)
   );

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; left = 1'b1; right = 1'b1;
      reset3 = 1'b0; left3 = 1'b0; right3 = 1'b0;
      #2;
      total++;
      if (L !== 3'b000 || R !== 3'b000)
         $display("FAIL reset_async: L=%b R=%b required L=000 R=000", L, R);
      else passed++;
      tick(); tick();
      total++;
      if (L !== 3'b000 || R !== 3'b000)
         $display("FAIL reset_held_inputs: L=%b R=%b required L=000 R=000", L, R);
      else passed++;
      reset = 1'b1; left = 1'b0; right = 1'b0;
      tick();
      total++;
      if (L !== 3'b000 || R !== 3'b000)
         $display("FAIL idle_after_reset: L=%b R=%b required L=000 R=000", L, R);
      else passed++;
   endtask

   task automatic test_left();
      logic [2:0] exp [5] = '{3'b100, 3'b110, 3'b111, 3'b000, 3'b100};
      left = 1'b1; right = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (L !== exp[i] || R !== 3'b000)
            $display("FAIL left_seq[%0d]: L=%b R=%b required L=%b R=000", i, L, R, exp[i]);
         else passed++;
      end
      // request dropped at L1: sequence still completes
      left = 1'b0;
      tick(); tick(); tick();
      total++;
      if (L !== 3'b000 || R !== 3'b000)
         $display("FAIL left_drain: L=%b R=%b required L=000 R=000", L, R);
      else passed++;
   endtask

   task automatic test_right();
      logic [2:0] exp [4] = '{3'b100, 3'b110, 3'b111, 3'b000};
      logic [2:0] drn [4] = '{3'b100, 3'b110, 3'b111, 3'b000};
      right = 1'b1; left = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (R !== exp[i] || L !== 3'b000)
            $display("FAIL right_seq[%0d]: L=%b R=%b required L=000 R=%b", i, L, R, exp[i]);
         else passed++;
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 0) right = 1'b0;   // drop request while in R1
         total++;
         if (R !== drn[i] || L !== 3'b000)
            $display("FAIL right_drop[%0d]: L=%b R=%b required L=000 R=%b", i, L, R, drn[i]);
         else passed++;
      end
      tick();
      total++;
      if (R !== 3'b000 || L !== 3'b000)
         $display("FAIL right_stays_idle: L=%b R=%b required L=000 R=000", L, R);
      else passed++;
   endtask

   task automatic test_hazard();
      logic [2:0] exl [4] = '{3'b100, 3'b111, 3'b000, 3'b111};
      logic [2:0] exr [4] = '{3'b000, 3'b000, 3'b000, 3'b111};
      left = 1'b1; right = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if ((i % 2 == 0) ? (L !== 3'b111 || R !== 3'b111) : (L !== 3'b000 || R !== 3'b000))
            $display("FAIL hazard_flash[%0d]: L=%b R=%b", i, L, R);
         else passed++;
      end
      // now in IDLE: go L1, L2, then request both
      right = 1'b0;
      tick();
      tick();
      total++;
      if (L !== 3'b110 || R !== 3'b000)
         $display("FAIL hazard_prep_L2: L=%b R=%b required L=110 R=000", L, R);
      else passed++;
      right = 1'b1;
      for (int i = 1; i < 4; i++) begin
         tick();
         total++;
         if (L !== exl[i] || R !== exr[i])
            $display("FAIL hazard_from_L2[%0d]: L=%b R=%b required L=%b R=%b",
                     i, L, R, exl[i], exr[i]);
         else passed++;
      end
   endtask

   task automatic test_reset_mid();
      // currently in HAZ, 1 unit past the edge
      #2 reset = 1'b0;
      #1;
      total++;
      if (L !== 3'b000 || R !== 3'b000)
         $display("FAIL reset_in_haz: L=%b R=%b required L=000 R=000", L, R);
      else passed++;
      right = 1'b0; left = 1'b1;
      tick(); tick();
      total++;
      if (L !== 3'b000 || R !== 3'b000)
         $display("FAIL reset_hold_left: L=%b R=%b required L=000 R=000", L, R);
      else passed++;
      reset = 1'b1;
      tick(); tick(); tick();
      total++;
      if (L !== 3'b111 || R !== 3'b000)
         $display("FAIL first_edge_after_reset: L=%b R=%b required L=111 R=000", L, R);
      else passed++;
      #3 reset = 1'b0;
      #1;
      total++;
      if (L !== 3'b000 || R !== 3'b000)
         $display("FAIL reset_in_L3: L=%b R=%b required L=000 R=000", L, R);
      else passed++;
      left = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic test_step3();
      logic [2:0] exp;
      reset3 = 1'b1; left3 = 1'b1; right3 = 1'b0;
      for (int e = 1; e <= 15; e++) begin
         tick();
         if (e < 3)        exp = 3'b000;
         else if (e < 6)   exp = 3'b100;
         else if (e < 9)   exp = 3'b110;
         else if (e < 12)  exp = 3'b111;
         else if (e < 15)  exp = 3'b000;
         else              exp = 3'b100;
         total++;
         if (L3o !== exp || R3o !== 3'b000)
            $display("FAIL step3_edge[%0d]: L=%b R=%b required L=%b R=000", e, L3o, R3o, exp);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_left();
      test_right();
      test_hazard();
      test_reset_mid();
      test_step3();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
